// File: rtl/input_port_buffer_if.sv
// Link-side and arbitration-side signals of one router input-port buffer.
// The buffer itself connects through the slave modport; the driving side uses master.
interface input_port_buffer_if #(
    parameter int DATA_W = 32,
    parameter int M      = 5,
    parameter int CNT_W  = 3
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic [M-1:0]      i_route;
    logic              o_en;
    logic [M-1:0]      o_output_req;
    logic              i_input_grant;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_count;
    logic              o_overflow;
    logic              o_route_err;
    logic              o_underflow;

    modport slave (
        input  i_valid, i_data, i_route, i_input_grant,
        output o_en, o_output_req, o_data, o_count,
        output o_overflow, o_route_err, o_underflow
    );

    modport master (
        output i_valid, i_data, i_route, i_input_grant,
        input  o_en, o_output_req, o_data, o_count,
        input  o_overflow, o_route_err, o_underflow
    );
endinterface

// File: rtl/input_port_buffer.sv
// Per-input-port flit FIFO: stores {route, data}, requests the head's output port,
// and pops the head in the cycle its input grant arrives.
module input_port_buffer #(
    parameter int DATA_W = 32,
    parameter int M      = 5,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 ce,
    input_port_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [M-1:0]      route;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rerr_q, rerr_d;
    logic             udf_q, udf_d;

    logic   route_ok;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;

    assign route_ok = (bus.i_route != '0) && ((bus.i_route & (bus.i_route - 1'b1)) == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop      = ce && bus.i_input_grant && !empty;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign push     = ce && bus.i_valid && route_ok && (!full || pop);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d    = ovf_q;
        rerr_d   = rerr_q;
        udf_d    = udf_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{route: bus.i_route, data: bus.i_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (ce && bus.i_valid && !route_ok) begin
            rerr_d = 1'b1;
        end
        if (ce && bus.i_valid && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (ce && bus.i_input_grant && empty) begin
            udf_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rerr_q   <= 1'b0;
            udf_q    <= 1'b0;
        end else if (ce) begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            rerr_q   <= rerr_d;
            udf_q    <= udf_d;
        end
    end

    // NOTE: storage is not reset; stale entries are never visible because outputs are gated by the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.o_en         = !full;
    assign bus.o_output_req = empty ? '0 : head.route;
    assign bus.o_data       = empty ? '0 : head.data;
    assign bus.o_count      = cnt_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_route_err  = rerr_q;
    assign bus.o_underflow  = udf_q;
endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a queue model.
module tb_input_port_buffer;
    localparam int DATA_W = 32;
    localparam int M      = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic clk;
    logic reset;
    logic ce;

    input_port_buffer_if #(.DATA_W(DATA_W), .M(M), .CNT_W(CNT_W)) bus ();

    input_port_buffer #(.DATA_W(DATA_W), .M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of {route, data} plus three sticky flags.
    logic [M+DATA_W-1:0] mq[$];
    logic m_ovf, m_rerr, m_udf;
    bit   model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_rerr   = 1'b0;
            m_udf    = 1'b0;
            model_ok = 1'b1;
        end else if (ce && model_ok) begin
            bit leaving;
            bit good_route;
            leaving    = bus.i_input_grant && (mq.size() > 0);
            good_route = ($countones(bus.i_route) == 1);
            if (bus.i_input_grant && mq.size() == 0) m_udf = 1'b1;
            if (bus.i_valid && !good_route) m_rerr = 1'b1;
            if (bus.i_valid && mq.size() == DEPTH && !leaving) m_ovf = 1'b1;
            if (leaving) void'(mq.pop_front());
            if (bus.i_valid && good_route && (mq.size() < DEPTH))
                mq.push_back({bus.i_route, bus.i_data});
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [M-1:0]      exp_req;
            logic [DATA_W-1:0] exp_data;
            exp_req  = '0;
            exp_data = '0;
            if (mq.size() > 0) {exp_req, exp_data} = mq[0];
            check("m_en",    64'(bus.o_en),         64'(mq.size() < DEPTH));
            check("m_count", 64'(bus.o_count),      64'(mq.size()));
            check("m_req",   64'(bus.o_output_req), 64'(exp_req));
            check("m_data",  64'(bus.o_data),       64'(exp_data));
            check("m_ovf",   64'(bus.o_overflow),   64'(m_ovf));
            check("m_rerr",  64'(bus.o_route_err),  64'(m_rerr));
            check("m_udf",   64'(bus.o_underflow),  64'(m_udf));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] r, input logic g);
        bus.i_valid       = v;
        bus.i_data        = d;
        bus.i_route       = r;
        bus.i_input_grant = g;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        drive(1'b0, '0, '0, 1'b0);

        // Reset then idle
        do_reset();
        check("rst_en",    64'(bus.o_en), 64'd1);
        check("rst_count", 64'(bus.o_count), 64'd0);
        check("rst_req",   64'(bus.o_output_req), 64'd0);
        check("rst_data",  64'(bus.o_data), 64'd0);
        check("rst_flags", 64'({bus.o_overflow, bus.o_route_err, bus.o_underflow}), 64'd0);

        // Single flit, one cycle of latency to the request
        drive(1'b1, 32'hA5A5_0001, 5'b00100, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b1);
        check("one_req",   64'(bus.o_output_req), 64'h04);
        check("one_data",  64'(bus.o_data), 64'hA5A5_0001);
        check("one_count", 64'(bus.o_count), 64'd1);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        check("one_pop_count", 64'(bus.o_count), 64'd0);
        check("one_pop_req",   64'(bus.o_output_req), 64'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + i, 5'(1 << i), 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0);
        check("fill_count", 64'(bus.o_count), 64'd4);
        check("fill_en",    64'(bus.o_en), 64'd0);
        drive(1'b1, 32'h0BAD, 5'b10000, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        check("ovf_flag",  64'(bus.o_overflow), 64'd1);
        check("ovf_count", 64'(bus.o_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 64'(bus.o_data), 64'(32'h1000 + i));
            check("drain_req",  64'(bus.o_output_req), 64'(1 << i));
            drive(1'b0, '0, '0, 1'b1);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0);
        check("drain_count", 64'(bus.o_count), 64'd0);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h2000 + i, 5'(1 << i), 1'b0);
            cycle();
        end
        drive(1'b1, 32'hDEAD_BEEF, 5'b10000, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        check("pp_count", 64'(bus.o_count), 64'd4);
        check("pp_ovf",   64'(bus.o_overflow), 64'd0);
        for (int i = 1; i < 4; i++) begin
            check("pp_order", 64'(bus.o_data), 64'(32'h2000 + i));
            drive(1'b0, '0, '0, 1'b1);
            cycle();
        end
        check("pp_last_data", 64'(bus.o_data), 64'hDEAD_BEEF);
        check("pp_last_req",  64'(bus.o_output_req), 64'h10);
        drive(1'b0, '0, '0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0);

        // Route error and underflow
        drive(1'b1, 32'h0000_0666, 5'b00110, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        check("rerr_flag",  64'(bus.o_route_err), 64'd1);
        check("rerr_count", 64'(bus.o_count), 64'd0);
        drive(1'b0, '0, '0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        check("udf_flag",  64'(bus.o_underflow), 64'd1);
        check("udf_count", 64'(bus.o_count), 64'd0);

        // Clock enable gating
        drive(1'b1, 32'h3000, 5'b00001, 1'b0);
        cycle();
        ce = 1'b0;
        drive(1'b1, 32'h3001, 5'b00010, 1'b1);
        cycle();
        cycle();
        check("ce_count", 64'(bus.o_count), 64'd1);
        check("ce_data",  64'(bus.o_data), 64'h3000);
        ce = 1'b1;

        // Streaming with a grant every cycle wraps the pointers
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h4000 + i, 5'(1 << (i % 5)), 1'b1);
            cycle();
            check("stream_count", 64'(bus.o_count), 64'd1);
            check("stream_data",  64'(bus.o_data), 64'(32'h4000 + i));
        end
        drive(1'b0, '0, '0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        check("stream_end", 64'(bus.o_count), 64'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] r;
            reset = ($urandom_range(0, 199) == 0);
            ce    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 85) r = 5'(1 << $urandom_range(0, 4));
            else r = 5'($urandom);
            drive($urandom_range(0, 99) < 60, $urandom, r, $urandom_range(0, 1) == 1);
            cycle();
        end
        reset = 1'b0;
        ce    = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/input_port_buffer.md
Name: input_port_buffer

Overview:
- Per-input-port flit buffer on the upstream side of the router's switch arbitration.
- Accepts flits from the upstream link, stores each flit with its pre-computed one-hot output route in a FIFO, and tells the upstream sender whether it can send (o_en).
- Presents the head flit's route as an output-port request to switch arbitration; pops the head when its input grant comes back.
- Instantiated once per input port (N copies per router).

Parameters:
- DATA_W, 32, flit payload width in bits.
- M, 5, number of router output ports (route vector width).
- DEPTH, 4, FIFO depth in flits; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  router clock.
- reset  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; no state changes when low.
- i_valid  input  1  upstream flit present this cycle.
- i_data  input  DATA_W  upstream flit payload.
- i_route  input  M  one-hot requested output port for this flit.
- o_en  output  1  buffer can accept a flit this cycle (to upstream router).
- o_output_req  output  M  head flit route, to switch arbitration; all zeros when empty.
- i_input_grant  input  1  arbitration granted this input; head flit departs this cycle.
- o_data  output  DATA_W  head flit payload, to crossbar.
- o_count  output  CNT_W  current occupancy.
- o_overflow  output  1  sticky: a write arrived while full with no pop.
- o_route_err  output  1  sticky: a flit arrived with a non-one-hot route.
- o_underflow  output  1  sticky: a grant arrived while empty.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {route, data}. Read and write pointers are log2(DEPTH) bits wide and wrap naturally. The occupancy count is held separately, 0..DEPTH.
- Reset (reset=1 at a clk edge, regardless of ce):
  - Pointers, count and sticky flags clear to 0.
  - Resulting outputs: o_en=1, o_output_req=0, o_count=0, o_data=0, all error flags=0.
  - Reset mid-operation discards all buffered flits; no grant or request persists into the next cycle.
- ce=0: pointers, count, storage and flags hold. Outputs keep reflecting the held state.
- o_en = (count < DEPTH). Combinational from registered count only; it never depends on i_valid or i_input_grant.
- pop = ce & i_input_grant & (count != 0).
  - Head advances at the edge.
  - o_data/o_output_req are valid combinationally in the grant cycle, so the crossbar transfers the flit in the same cycle.
- push = ce & i_valid & onehot(i_route) & (count < DEPTH | pop).
  - Writes at the write pointer.
  - Push when full is permitted only with a simultaneous pop.
- Count update: count += push − pop.
  - Simultaneous push and pop leaves count unchanged.
  - Simultaneous push and pop when empty is impossible (pop requires count≠0): a new flit arriving into an empty buffer is not visible until the next cycle. Latency is 1 cycle from accept to request.
- o_output_req = route at head when count≠0, else 0. o_data = payload at head when count≠0, else 0.
- Error handling:
  - i_valid with zero or multi-hot i_route: the flit is dropped and o_route_err is set (ce=1).
  - i_valid with count=DEPTH and no pop: the flit is dropped and o_overflow is set.
  - i_input_grant with count=0: ignored, and o_underflow is set.
  - Sticky flags clear only on reset.
- Strict FIFO order; no flit is reordered or duplicated.

Test Plan:
- Reset then idle: assert reset 2 cycles -> o_en=1, o_count=0, o_output_req=5'b00000, all flags 0.
- Single flit: i_valid=1, i_data=32'hA5A5_0001, i_route=5'b00100 in cycle t.
  - At t+1: o_output_req=5'b00100, o_data=32'hA5A5_0001, o_count=1.
  - Grant at t+1 -> at t+2: o_count=0, o_output_req=0.
- Fill and backpressure: push 4 flits (routes 00001, 00010, 00100, 01000) with no grant -> o_count=4, o_en=0.
  - A 5th push with no grant -> dropped, o_overflow=1.
  - Then 4 grants -> flits emerge in order.
- Full with simultaneous push/pop: at count=4, grant plus push of 32'hDEAD_BEEF, route 10000 -> o_count stays 4, o_overflow stays 0. The new flit is the 4th out after further grants.
- Errors: push with route 5'b00110 -> not stored, o_route_err=1. Grant at count=0 -> o_underflow=1, o_count=0.
- ce gating and wrap: with ce=0, apply push and grant -> no change. With ce=1, stream 10 flits with a grant every cycle -> pointers wrap, order preserved, o_count ≤ 1.
